cond_logic: RTL and testbench
=============================

COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port: Cond  input  4  instruction condition field, Instr[31:28].
REQ-004 SHALL have port: ALUFlags  input  4  ALU result flags {N,Z,C,V}, bit 3 = N.
REQ-005 SHALL have port: FlagW  input  2  flag-write request from the decoder; bit 1 = N/Z group, bit 0 = C/V group.
REQ-006 SHALL have port: PCS  input  1  PC-source request from the decoder (Rd=R15 write or branch).
REQ-007 SHALL have port: NextPC  input  1  unconditional PC update from the main FSM (fetch).
REQ-008 SHALL have port: RegW  input  1  register-write request from the main FSM.
REQ-009 SHALL have port: MemW  input  1  memory-write request from the main FSM.
REQ-010 SHALL have port: PCWrite  output  1  PC register enable.
REQ-011 SHALL have port: RegWrite  output  1  register-file write enable.
REQ-012 SHALL have port: MemWrite  output  1  data-memory write enable.
REQ-013 SHALL have port: Flags  output  4  current architectural flag register {N,Z,C,V}, for observation.

Function
REQ-014 SHALL hold a 4-bit flag register split into two independently enabled 2-bit groups: {N,Z} = Flags[3:2] and {C,V} = Flags[1:0].
REQ-015 SHALL compute CondEx combinationally from Cond and the registered Flags (not ALUFlags): 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 1 (treated as unconditional).
REQ-016 SHALL form FlagWrite[1:0] = FlagW[1:0] AND {CondEx,CondEx}.
REQ-017 SHALL load Flags[3:2] from ALUFlags[3:2] on a clock edge when FlagWrite[1]=1, and Flags[1:0] from ALUFlags[1:0] when FlagWrite[0]=1; an unenabled group holds its value.
REQ-018 SHALL hold a 1-bit register CondExDelayed that samples CondEx on every rising clock edge (one-cycle latency, no enable).
REQ-019 SHALL drive RegWrite = RegW AND CondExDelayed, MemWrite = MemW AND CondExDelayed, combinationally.
REQ-020 SHALL drive PCWrite = (PCS AND CondExDelayed) OR NextPC; NextPC SHALL force PCWrite=1 regardless of condition.
REQ-021 SHALL, when both flag groups are written in the same cycle, update all four bits atomically on that edge.
REQ-022 SHALL evaluate CondEx for the sampling edge using the pre-update Flags; a flag update on edge k SHALL affect CondEx only from cycle k+1.
REQ-023 SHALL introduce no latch; all outputs are defined for every input combination, including Cond=1111 and X-free FlagW=00.

Reset
REQ-024 SHALL, while reset=0, asynchronously force Flags=4'b0000 and CondExDelayed=0, irrespective of clk.
REQ-025 SHALL therefore drive RegWrite=0, MemWrite=0 and PCWrite=NextPC during reset.
REQ-026 SHALL resume normal operation on the first rising clk edge after reset returns to 1; reset asserted mid-instruction SHALL discard any pending CondExDelayed and flag update.

Verification
REQ-027 Reset: reset=0 with ALUFlags=1111, FlagW=11 toggling clk -> Flags stays 0000, RegWrite=MemWrite=0, PCWrite follows NextPC.
REQ-028 Flag write: Flags=0000, Cond=1110, ALUFlags=0100, FlagW=11, one edge -> Flags=0100; next Cond=0000 (EQ) -> CondEx=1, CondExDelayed=1 after one edge, RegW=1 -> RegWrite=1.
REQ-029 Partial write: Flags=1111, Cond=1110, ALUFlags=0000, FlagW=10, one edge -> Flags=0011 (C,V preserved).
REQ-030 Condition fail: Flags=0000, Cond=0000 (EQ), FlagW=11, ALUFlags=1111 -> Flags unchanged 0000; after edge RegW=1, MemW=1, PCS=1, NextPC=0 -> RegWrite=MemWrite=PCWrite=0.
REQ-031 Signed compares: sweep all 16 Flags values x 16 Cond codes -> CondEx matches REQ-015 table; spot check Flags=1001 (N=1,V=1): GE=1, LT=0, GT=1, LE=0.
REQ-032 Fetch override: CondExDelayed=0, NextPC=1, PCS=0 -> PCWrite=1; NextPC=0, PCS=1 -> PCWrite=0.

Source files
------------

// File: rtl/cond_logic.sv
// Conditional-execution unit: evaluates the instruction condition field
// against the architectural flag register, gates the write enables coming
// from the main FSM, and updates the {N,Z} / {C,V} flag groups.
module cond_logic (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       NextPC,
   input  logic       RegW,
   input  logic       MemW,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic [3:0] Flags
);

   logic [1:0] flags_nz_q, flags_nz_d;
   logic [1:0] flags_cv_q, flags_cv_d;
   logic       cond_ex_dly_q, cond_ex_dly_d;
   logic       cond_base;
   logic       cond_ex;
   logic [1:0] flag_write;
   logic       n, z, c, v;

   assign Flags = {flags_nz_q, flags_cv_q};
   assign n     = flags_nz_q[1];
   assign z     = flags_nz_q[0];
   assign c     = flags_cv_q[1];
   assign v     = flags_cv_q[0];

   // Condition evaluation: even codes give the base test, odd codes its
   // complement; 4'b1111 is treated as unconditional like AL.
   always_comb begin
      cond_base = 1'b0;
      case (Cond[3:1])
         3'b000:  cond_base = z;
         3'b001:  cond_base = c;
         3'b010:  cond_base = n;
         3'b011:  cond_base = v;
         3'b100:  cond_base = c & ~z;
         3'b101:  cond_base = ~(n ^ v);
         3'b110:  cond_base = ~z & ~(n ^ v);
         default: cond_base = 1'b1;
      endcase
      cond_ex = (Cond == 4'b1111) ? 1'b1 : (cond_base ^ Cond[0]);
   end

   // Next-state for the flag groups and the delayed condition bit.
   always_comb begin
      flag_write    = FlagW & {cond_ex, cond_ex};
      flags_nz_d    = flag_write[1] ? ALUFlags[3:2] : flags_nz_q;
      flags_cv_d    = flag_write[0] ? ALUFlags[1:0] : flags_cv_q;
      cond_ex_dly_d = cond_ex;
   end

   // Flag register and delayed condition; async active-low clear discards
   // any pending update.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_nz_q    <= 2'b00;
         flags_cv_q    <= 2'b00;
         cond_ex_dly_q <= 1'b0;
      end else begin
         flags_nz_q    <= flags_nz_d;
         flags_cv_q    <= flags_cv_d;
         cond_ex_dly_q <= cond_ex_dly_d;
      end
   end

   // Write enables gated by the previous cycle's condition; fetch forces PC.
   always_comb begin
      RegWrite = RegW & cond_ex_dly_q;
      MemWrite = MemW & cond_ex_dly_q;
      PCWrite  = (PCS & cond_ex_dly_q) | NextPC;
   end

endmodule

// File: tb/tb_cond_logic.sv
// Bench for cond_logic: flag/condition model plus directed vectors.
module tb_cond_logic;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS, NextPC, RegW, MemW;
   logic       PCWrite, RegWrite, MemWrite;
   logic [3:0] Flags;

   int total = 0;
   int bad   = 0;

   // literal expectation handed to the compare process
   logic       lit_on = 1'b0;
   string      lit_name = "";
   logic [3:0] lit_mask = 4'b0000; // {flags, RegWrite, MemWrite, PCWrite}
   logic [3:0] lit_flags = 4'b0000;
   logic       lit_rw = 1'b0, lit_mw = 1'b0, lit_pw = 1'b0;

   // model state
   logic [3:0] m_flags = 4'b0000;
   logic       m_prev  = 1'b0;

   cond_logic dut (
      .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
      .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
      .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .Flags(Flags)
   );

   always #5 clk = ~clk;

   // condition truth straight from the mnemonic table
   function automatic logic cond_true(input logic [3:0] cc, input logic [3:0] f);
      logic nn, zz, cy, vv;
      nn = f[3]; zz = f[2]; cy = f[1]; vv = f[0];
      case (cc)
         4'd0:  return zz;
         4'd1:  return !zz;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return nn;
         4'd5:  return !nn;
         4'd6:  return vv;
         4'd7:  return !vv;
         4'd8:  return cy && !zz;
         4'd9:  return !cy || zz;
         4'd10: return nn == vv;
         4'd11: return nn != vv;
         4'd12: return !zz && (nn == vv);
         4'd13: return zz || (nn != vv);
         default: return 1'b1;
      endcase
   endfunction

   // model: condition uses flags as they were before the edge
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_flags <= 4'b0000;
         m_prev  <= 1'b0;
      end else begin
         if (cond_true(Cond, m_flags)) begin
            if (FlagW[1]) m_flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0]) m_flags[1:0] <= ALUFlags[1:0];
         end
         m_prev <= cond_true(Cond, m_flags);
      end
   end

   // compare process: every falling edge against model, plus literal pins
   always @(negedge clk) begin
      total = total + 1;
      if (Flags !== m_flags) begin
         bad = bad + 1;
         $display("FAIL model_flags t=%0t got=%b want=%b", $time, Flags, m_flags);
      end
      total = total + 1;
      if (RegWrite !== (RegW & m_prev)) begin
         bad = bad + 1;
         $display("FAIL model_regwrite t=%0t got=%b want=%b", $time, RegWrite, RegW & m_prev);
      end
      total = total + 1;
      if (MemWrite !== (MemW & m_prev)) begin
         bad = bad + 1;
         $display("FAIL model_memwrite t=%0t got=%b want=%b", $time, MemWrite, MemW & m_prev);
      end
      total = total + 1;
      if (PCWrite !== ((PCS & m_prev) | NextPC)) begin
         bad = bad + 1;
         $display("FAIL model_pcwrite t=%0t got=%b want=%b", $time, PCWrite, (PCS & m_prev) | NextPC);
      end
      if (lit_on) begin
         if (lit_mask[3]) begin
            total = total + 1;
            if (Flags !== lit_flags) begin
               bad = bad + 1;
               $display("FAIL %s Flags got=%b want=%b", lit_name, Flags, lit_flags);
            end
         end
         if (lit_mask[2]) begin
            total = total + 1;
            if (RegWrite !== lit_rw) begin
               bad = bad + 1;
               $display("FAIL %s RegWrite got=%b want=%b", lit_name, RegWrite, lit_rw);
            end
         end
         if (lit_mask[1]) begin
            total = total + 1;
            if (MemWrite !== lit_mw) begin
               bad = bad + 1;
               $display("FAIL %s MemWrite got=%b want=%b", lit_name, MemWrite, lit_mw);
            end
         end
         if (lit_mask[0]) begin
            total = total + 1;
            if (PCWrite !== lit_pw) begin
               bad = bad + 1;
               $display("FAIL %s PCWrite got=%b want=%b", lit_name, PCWrite, lit_pw);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [3:0] mask, input logic [3:0] f,
                      input logic rw, input logic mw, input logic pw);
      lit_name  = nm;
      lit_mask  = mask;
      lit_flags = f;
      lit_rw    = rw;
      lit_mw    = mw;
      lit_pw    = pw;
      lit_on    = 1'b1;
      @(negedge clk);
      #1;
      lit_on    = 1'b0;
   endtask

   task automatic load_flags(input logic [3:0] f);
      Cond = 4'b1110; ALUFlags = f; FlagW = 2'b11;
      tick();
   endtask

   initial begin
      // reset held with an aggressive flag-write request
      reset = 1'b0; Cond = 4'b1110; ALUFlags = 4'b1111; FlagW = 2'b11;
      RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; NextPC = 1'b0;
      tick(); tick();
      chk("rst_hold", 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
      NextPC = 1'b1;
      chk("rst_fetch", 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1);

      tick();
      reset = 1'b1; FlagW = 2'b00; RegW = 1'b0; MemW = 1'b0; PCS = 1'b0;
      NextPC = 1'b0; Cond = 4'b1110; ALUFlags = 4'b0000;

      // full flag write then EQ/NE against Z=1
      tick();
      Cond = 4'b1110; ALUFlags = 4'b0100; FlagW = 2'b11;
      tick();
      Cond = 4'b0001; FlagW = 2'b00; RegW = 1'b1;
      chk("fw_load", 4'b1000, 4'b0100, 1'b0, 1'b0, 1'b0);
      tick();
      Cond = 4'b0000;
      chk("ne_fail", 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
      tick();
      chk("eq_pass", 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0);

      // partial write keeps C,V
      load_flags(4'b1111);
      ALUFlags = 4'b0000; FlagW = 2'b10;
      chk("fw_all", 4'b1000, 4'b1111, 1'b0, 1'b0, 1'b0);
      tick();
      FlagW = 2'b00;
      chk("fw_partial", 4'b1000, 4'b0011, 1'b0, 1'b0, 1'b0);

      // failed condition blocks flags and all enables
      load_flags(4'b0000);
      Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1111;
      RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; NextPC = 1'b0;
      tick();
      FlagW = 2'b00;
      chk("cond_fail", 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);

      // fetch override with the delayed condition false
      NextPC = 1'b1; PCS = 1'b0;
      chk("fetch_force", 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1);
      tick();
      NextPC = 1'b0; PCS = 1'b1;
      chk("fetch_off", 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
      PCS = 1'b0; MemW = 1'b0;

      // signed compares with N=1, V=1
      load_flags(4'b1001);
      FlagW = 2'b00; Cond = 4'b1010; tick();
      chk("ge_nv", 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0);
      Cond = 4'b1011; tick();
      chk("lt_nv", 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
      Cond = 4'b1100; tick();
      chk("gt_nv", 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0);
      Cond = 4'b1101; tick();
      chk("le_nv", 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);

      // full sweep of flags x condition codes
      RegW = 1'b1;
      for (int f = 0; f < 16; f++) begin
         for (int cc = 0; cc < 16; cc++) begin
            load_flags(f[3:0]);
            Cond = cc[3:0]; FlagW = 2'b00;
            tick();
         end
      end

      // reset mid-instruction discards the pending update
      load_flags(4'b1111);
      Cond = 4'b1110; ALUFlags = 4'b0101; FlagW = 2'b11; NextPC = 1'b0; PCS = 1'b1;
      #2;
      reset = 1'b0;
      chk("rst_async", 4'b1101, 4'b0000, 1'b0, 1'b0, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      FlagW = 2'b00;
      chk("post_rst", 4'b1000, 4'b0101, 1'b0, 1'b0, 1'b0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
